// File: rtl/nios_cpu_gpio_in_irq_if.sv
// rtl/nios_cpu_gpio_in_irq_if.sv - Avalon-MM slave bus bundle for the GPIO input PIO
// Ports (signals):
//   address    : 3-bit word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (slave output)
interface nios_cpu_gpio_in_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_cpu_gpio_in_irq.sv
// rtl/nios_cpu_gpio_in_irq.sv - parametrised input PIO with edge capture and level irq
// Ports:
//   clk     : system clock, all registers on its rising edge
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port : asynchronous external inputs, WIDTH bits
//   irq     : level interrupt, OR of (edge_capture & irq_mask)
// Register map: 0 DATA (ro), 2 IRQ_MASK (rw), 3 EDGE_CAPTURE (w1c), others read 0.
module nios_cpu_gpio_in_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios_cpu_gpio_in_irq_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_out;
    logic [WIDTH-1:0]                  prev;
    logic [WIDTH-1:0]                  irq_mask;
    logic [WIDTH-1:0]                  edge_capture;
    logic [ARM_W-1:0]                  arm_cnt;
    logic                              armed;
    logic [WIDTH-1:0]                  edges;
    logic [WIDTH-1:0]                  cap_set;
    logic [WIDTH-1:0]                  cap_clr;
    logic                              wr;
    logic                              wr_mask;
    logic                              wr_clr;
    logic [31:0]                       rd_mux;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_cnt == ARM_DONE);

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_mask = wr && (bus.address == 3'd2);
    assign wr_clr  = wr && (bus.address == 3'd3);

    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            1:       edges = ~sync_out & prev;
            2:       edges = sync_out ^ prev;
            default: edges = sync_out & ~prev;
        endcase
    end

    // Edges are ignored until the synchroniser and prev have settled after
    // reset, so a pin that is already high does not look like a rising edge.
    assign cap_set = armed ? edges : '0;
    assign cap_clr = wr_clr ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0:    rd_mux = 32'(sync_out);
            3'd2:    rd_mux = 32'(irq_mask);
            3'd3:    rd_mux = 32'(edge_capture);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '0;
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            arm_cnt      <= '0;
            bus.readdata <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            end
            prev <= sync_out;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            if (wr_mask) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
            // Set wins over a simultaneous write-1-to-clear.
            edge_capture <= (edge_capture & ~cap_clr) | cap_set;
            // Mux samples pre-write register values, so a same-cycle read
            // returns the old contents.
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_cpu_gpio_in_irq.sv
// tb/tb_nios_cpu_gpio_in_irq.sv - scoreboard bench for the GPIO input PIO
module tb_nios_cpu_gpio_in_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_a = 8'hFF;
    logic [31:0] in_b = 32'h0;
    logic        irq_a;
    logic        irq_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    nios_cpu_gpio_in_irq_if bus_a ();
    nios_cpu_gpio_in_irq_if bus_b ();

    nios_cpu_gpio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a),
        .in_port (in_a),
        .irq     (irq_a)
    );

    nios_cpu_gpio_in_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b),
        .in_port (in_b),
        .irq     (irq_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = 3'd0; bus_a.writedata = '0;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.address = 3'd0; bus_b.writedata = '0;
    endtask

    // All bus tasks start and end right after a falling edge.
    task automatic bus_write(input bit sel, input logic [2:0] addr, input logic [31:0] data);
        if (sel) begin
            bus_b.address = addr; bus_b.writedata = data; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        end else begin
            bus_a.address = addr; bus_a.writedata = data; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input bit sel, input logic [2:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        if (sel) begin
            bus_b.address = addr; bus_b.chipselect = 1'b1;
        end else begin
            bus_a.address = addr; bus_a.chipselect = 1'b1;
        end
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        got = sel ? bus_b.readdata : bus_a.readdata;
        check(tag_q.pop_front(), got, exp_q.pop_front());
        bus_idle();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus_idle();
        cycles(3);
        reset_n = 1'b1;
        cycles(10);

        // Reset defaults with inputs held high
        bus_read(0, 3'd0, 32'h0000_00FF, "a_data_reset");
        bus_read(0, 3'd3, 32'h0, "a_cap_after_reset");
        check("a_irq_reset", {31'b0, irq_a}, 32'h0);
        bus_read(0, 3'd2, 32'h0, "a_mask_reset");

        in_a = 8'h00;
        cycles(5);
        bus_read(0, 3'd3, 32'h0, "a_no_fall_cap");

        // Rising capture with interrupt, 2-stage latency
        bus_write(0, 3'd2, 32'h05);
        in_a = 8'h01;
        cycles(2);
        check("a_irq_before_latency", {31'b0, irq_a}, 32'h0);
        cycles(1);
        check("a_irq_at_latency", {31'b0, irq_a}, 32'h1);
        bus_read(0, 3'd3, 32'h1, "a_cap_bit0");

        // Write-1-to-clear
        in_a = 8'h81;
        cycles(4);
        bus_read(0, 3'd3, 32'h81, "a_cap_81");
        bus_write(0, 3'd3, 32'h01);
        bus_read(0, 3'd3, 32'h80, "a_cap_w1c");
        check("a_irq_after_w1c", {31'b0, irq_a}, 32'h0);

        // Set and clear on bit1 in the same cycle: set wins
        in_a = 8'h83;
        cycles(2);
        bus_write(0, 3'd3, 32'h02);
        bus_read(0, 3'd3, 32'h82, "a_set_beats_clr");

        // Mask gating and upper writedata bits
        bus_write(0, 3'd3, 32'hFF);
        bus_write(0, 3'd2, 32'h0);
        in_a = 8'h00;
        cycles(4);
        in_a = 8'h80;
        cycles(4);
        bus_read(0, 3'd3, 32'h80, "a_cap_bit7");
        check("a_irq_masked", {31'b0, irq_a}, 32'h0);
        bus_write(0, 3'd2, 32'hFFFF_FF80);
        check("a_irq_unmasked", {31'b0, irq_a}, 32'h1);
        bus_read(0, 3'd2, 32'h80, "a_mask_trunc");
        bus_write(0, 3'd2, 32'h0);
        check("a_irq_mask_drop", {31'b0, irq_a}, 32'h0);
        bus_read(0, 3'd3, 32'h80, "a_cap_kept");
        bus_write(0, 3'd2, 32'h80);

        // Wide, any-edge instance
        bus_write(1, 3'd2, 32'hFFFF_FFFF);
        in_b = 32'h8000_0000;
        cycles(4);
        bus_read(1, 3'd3, 32'h8000_0000, "b_cap_rise31");
        check("b_irq_rise", {31'b0, irq_b}, 32'h1);
        bus_write(1, 3'd3, 32'h8000_0000);
        bus_read(1, 3'd3, 32'h0, "b_cap_cleared");
        check("b_irq_cleared", {31'b0, irq_b}, 32'h0);
        in_b = 32'h0;
        cycles(4);
        bus_read(1, 3'd3, 32'h8000_0000, "b_cap_fall31");
        in_b = 32'h0000_00A5;
        cycles(4);
        bus_read(1, 3'd0, 32'h0000_00A5, "b_data");
        for (int a = 1; a < 8; a++) begin
            if (a == 2 || a == 3) continue;
            bus_read(1, 3'(a), 32'h0, $sformatf("b_rsvd_%0d", a));
        end
        bus_write(1, 3'd0, 32'hFFFF_FFFF);
        bus_read(1, 3'd0, 32'h0000_00A5, "b_data_ro");

        // Asynchronous reset mid-sequence
        check("b_irq_pre_reset", {31'b0, irq_b}, 32'h1);
        check("a_irq_pre_reset", {31'b0, irq_a}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("b_irq_async_rst", {31'b0, irq_b}, 32'h0);
        check("a_irq_async_rst", {31'b0, irq_a}, 32'h0);
        check("b_rd_async_rst", bus_b.readdata, 32'h0);
        check("a_rd_async_rst", bus_a.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(6);
        bus_read(1, 3'd2, 32'h0, "b_mask_after_rst");
        bus_read(1, 3'd3, 32'h0, "b_cap_after_rst");
        bus_read(0, 3'd3, 32'h0, "a_cap_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
